serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 151 +++++++++++++++
 tb/tb_serial_adder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are latched on start, added LSB first one bit per
// cycle, and the registered sum/carry are published with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             bit_s;
    logic             carry_s;
    logic [WIDTH-1:0] res_shift_s;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Full-adder slice on the operand LSBs; the shift form also covers WIDTH=1
    always_comb begin
        bit_s       = a_q[0] ^ b_q[0] ^ c_q;
        carry_s     = majority(a_q[0], b_q[0], c_q);
        res_shift_s = (WIDTH'(bit_s) << (WIDTH - 1)) | (res_q >> 1);
    end

    // State register and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = FIN;
                end else begin
                    state_d = ADD;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; sum/cy only change on the last ADD edge
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        sum_d = sum_q;
        c_d   = c_q;
        cy_d  = cy_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    c_d   = 1'b0;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ADD: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift_s;
                c_d   = carry_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d = res_shift_s;
                    cy_d  = carry_s;
                end else begin
                    sum_d = sum_q;
                end
            end
            FIN:     cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            IDLE:    busy = 1'b0;
            ADD:     busy = 1'b1;
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
        sum = sum_q;
        cy  = cy_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked
// cycle by cycle against an arithmetic reference (a+b with carry-out).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       busy8, done8, cy8;
    logic [7:0] sum8;
    logic       busy1, done1, cy1;
    logic [0:0] sum1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] prev_sum;
    logic       prev_cy;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cy(cy8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cy(cy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 addition, watched for W+1 edges after the accepting edge
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input bit zero_after,
                        input bit hammer_start, input string tag);
        logic [8:0] expv;
        expv   = {1'b0, ta} + {1'b0, tb};
        a8     = ta;
        b8     = tb;
        start8 = 1'b1;
        @(posedge clk); #1;
        a8     = zero_after ? 8'h00 : 8'($urandom);
        b8     = zero_after ? 8'h00 : 8'($urandom);
        start8 = hammer_start ? 1'($urandom) : 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check({tag, "_busy"}, {31'd0, busy8}, {31'd0, (k <= 8)});
            check({tag, "_done"}, {31'd0, done8}, {31'd0, (k == 8)});
            if (k < 8) begin
                check({tag, "_sum_hold"}, {24'd0, sum8}, {24'd0, prev_sum});
                check({tag, "_cy_hold"}, {31'd0, cy8}, {31'd0, prev_cy});
            end else begin
                check({tag, "_sum"}, {24'd0, sum8}, {24'd0, expv[7:0]});
                check({tag, "_cy"}, {31'd0, cy8}, {31'd0, expv[8]});
            end
            if (!zero_after) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            start8 = (hammer_start && k < 9) ? 1'($urandom) : 1'b0;
        end
        prev_sum = expv[7:0];
        prev_cy  = expv[8];
    endtask

    initial begin
        logic [8:0] expv;
        logic [1:0] e1;
        reset_n = 1'b0;
        start8 = 1'b1; start1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; a1 = 1'b1; b1 = 1'b1;
        prev_sum = 8'h00; prev_cy = 1'b0;

        // Reset must win over start
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_sum", {24'd0, sum8}, 32'd0);
        check("rst_cy", {31'd0, cy8}, 32'd0);
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        start8 = 1'b0; start1 = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", {31'd0, busy8}, 32'd0);

        run8(8'h00, 8'h00, 1'b0, 1'b0, "zero");
        run8(8'hFF, 8'h01, 1'b0, 1'b0, "ff_p1");
        run8(8'hA5, 8'h5A, 1'b1, 1'b0, "a5_5a");

        // Abort in the 4th ADD cycle: sum/cy clear and no done ever appears
        a8 = 8'h3C; b8 = 8'h77; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_sum", {24'd0, sum8}, 32'd0);
        check("abort_cy", {31'd0, cy8}, 32'd0);
        prev_sum = 8'h00; prev_cy = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("abort_no_done", {31'd0, done8}, 32'd0);
        end

        // start held high: a done every 10 edges, busy low only 1 in 10
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            check("b2b_done", {31'd0, done8}, {31'd0, (k % 10 == 8)});
            check("b2b_busy", {31'd0, busy8}, {31'd0, (k % 10 != 9)});
            if (k % 10 == 8) begin
                check("b2b_sum", {24'd0, sum8}, 32'd0);
                check("b2b_cy", {31'd0, cy8}, 32'd1);
            end
        end
        start8 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        prev_sum = 8'h00; prev_cy = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run8(8'($urandom), 8'($urandom), 1'b0, 1'b1, "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // WIDTH=1: one ADD cycle, done on the following edge
        for (int i = 0; i < 4; i++) begin
            a1 = 1'(i >> 1);
            b1 = 1'(i);
            e1 = {1'b0, a1} + {1'b0, b1};
            start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            check("w1_busy", {31'd0, busy1}, 32'd1);
            check("w1_done_early", {31'd0, done1}, 32'd0);
            @(posedge clk); #1;
            check("w1_done", {31'd0, done1}, 32'd1);
            check("w1_sum", {31'd0, sum1}, {31'd0, e1[0]});
            check("w1_cy", {31'd0, cy1}, {31'd0, e1[1]});
            @(posedge clk); #1;
            check("w1_idle", {31'd0, busy1}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
